or1200_rf_wb: RTL and testbench

OR1200_RF_WB -- requirements
Module: or1200_rf_wb

---
 rtl/or1200_rf_wb_pkg.sv | 24 ++
 rtl/or1200_rf_wb_if.sv | 37 +++
 rtl/or1200_rf_fwd_cmp.sv | 32 +++
 rtl/or1200_rf_wb.sv | 110 +++++++++++
 tb/tb_or1200_rf_wb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/or1200_rf_wb_pkg.sv
// Shared widths, stage-state encoding and helpers for the OR1200 dual-issue GPR writeback stage.
package or1200_rf_wb_pkg;

  localparam int unsigned RF_AW    = 5;
  localparam int unsigned RF_DW    = 32;
  localparam int unsigned RF_CW    = 16;
  localparam int unsigned RD_PORTS = 4;

  // Encoding equals the number of effective writes held in the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_e;

  function automatic stage_e stage_of(input logic we1, input logic we2);
    case ({we1, we2})
      2'b00:   return ST_EMPTY;
      2'b11:   return ST_TWO;
      default: return ST_ONE;
    endcase
  endfunction

endpackage

// File: rtl/or1200_rf_wb_if.sv
// Execute-result, control, read-address and write-port bundle of the writeback stage.
interface or1200_rf_wb_if #(
  parameter int unsigned aw = 5,
  parameter int unsigned dw = 32,
  parameter int unsigned cw = 16
);
  logic              ex_valid;
  logic [aw-1:0]     ex_addr;
  logic [dw-1:0]     ex_data;
  logic              ex_valid2;
  logic [aw-1:0]     ex_addr2;
  logic [dw-1:0]     ex_data2;
  logic              wb_freeze;
  logic              flushpipe;
  logic [4*aw-1:0]   rd_addr;
  logic [aw-1:0]     addrw;
  logic [dw-1:0]     dataw;
  logic              we;
  logic [aw-1:0]     addrw2;
  logic [dw-1:0]     dataw2;
  logic              we2;
  logic [3:0]        fwd_hit;
  logic [4*dw-1:0]   fwd_data;
  logic [cw-1:0]     commit_cnt;

  modport master (
    output ex_valid, ex_addr, ex_data, ex_valid2, ex_addr2, ex_data2,
           wb_freeze, flushpipe, rd_addr,
    input  addrw, dataw, we, addrw2, dataw2, we2, fwd_hit, fwd_data, commit_cnt
  );

  modport slave (
    input  ex_valid, ex_addr, ex_data, ex_valid2, ex_addr2, ex_data2,
           wb_freeze, flushpipe, rd_addr,
    output addrw, dataw, we, addrw2, dataw2, we2, fwd_hit, fwd_data, commit_cnt
  );
endinterface

// File: rtl/or1200_rf_fwd_cmp.sv
// One bypass comparator: matches a read address against both writeback slots, younger slot first.
module or1200_rf_fwd_cmp #(
  parameter int unsigned aw = 5,
  parameter int unsigned dw = 32
) (
  input  logic [aw-1:0] rd_addr,
  input  logic          we,
  input  logic [aw-1:0] addrw,
  input  logic [dw-1:0] dataw,
  input  logic          we2,
  input  logic [aw-1:0] addrw2,
  input  logic [dw-1:0] dataw2,
  output logic          hit_c,
  output logic [dw-1:0] data_c
);

  logic hit1_c;
  logic hit2_c;

  always_comb begin
    hit1_c = we  && (addrw  == rd_addr) && (rd_addr != '0);
    hit2_c = we2 && (addrw2 == rd_addr) && (rd_addr != '0);
    hit_c  = hit1_c || hit2_c;
    data_c = '0;
    if (hit2_c) begin
      data_c = dataw2;
    end else if (hit1_c) begin
      data_c = dataw;
    end
  end

endmodule

// File: rtl/or1200_rf_wb.sv
// Dual-slot GPR writeback stage: registers execute results, drives two RF write ports,
// bypasses in-flight results to four read ports and counts committed writes.
module or1200_rf_wb
  import or1200_rf_wb_pkg::*;
#(
  parameter int unsigned aw = RF_AW,
  parameter int unsigned dw = RF_DW,
  parameter int unsigned cw = RF_CW
) (
  input logic           clk,
  input logic           rst_n,
  or1200_rf_wb_if.slave bus
);

  logic          we_q,    we_d;
  logic          we2_q,   we2_d;
  logic [aw-1:0] addr_q,  addr_d;
  logic [aw-1:0] addr2_q, addr2_d;
  logic [dw-1:0] data_q,  data_d;
  logic [dw-1:0] data2_q, data2_d;
  logic [cw-1:0] cnt_q,   cnt_d;
  stage_e        state_q, state_d;

  logic          cap_we_c;
  logic          cap_we2_c;
  logic [RD_PORTS-1:0]    hit_c;
  logic [RD_PORTS*dw-1:0] fwd_data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      we2_q   <= 1'b0;
      addr_q  <= '0;
      addr2_q <= '0;
      data_q  <= '0;
      data2_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      we_q    <= we_d;
      we2_q   <= we2_d;
      addr_q  <= addr_d;
      addr2_q <= addr2_d;
      data_q  <= data_d;
      data2_q <= data2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Enables are resolved at capture (r0 and same-address collision) so the write port is a pure flop.
  always_comb begin
    cap_we2_c = bus.ex_valid2 && (bus.ex_addr2 != '0);
    cap_we_c  = bus.ex_valid && (bus.ex_addr != '0) &&
                !(cap_we2_c && (bus.ex_addr2 == bus.ex_addr));

    we_d    = we_q;
    we2_d   = we2_q;
    addr_d  = addr_q;
    addr2_d = addr2_q;
    data_d  = data_q;
    data2_d = data2_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    // State encoding doubles as the per-cycle commit increment.
    if (!bus.wb_freeze && !bus.flushpipe) begin
      cnt_d = cnt_q + cw'(state_q);
    end

    if (bus.flushpipe) begin
      we_d    = 1'b0;
      we2_d   = 1'b0;
      state_d = ST_EMPTY;
    end else if (!bus.wb_freeze) begin
      we_d    = cap_we_c;
      we2_d   = cap_we2_c;
      addr_d  = bus.ex_addr;
      addr2_d = bus.ex_addr2;
      data_d  = bus.ex_data;
      data2_d = bus.ex_data2;
      state_d = stage_of(cap_we_c, cap_we2_c);
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_fwd
    or1200_rf_fwd_cmp #(.aw(aw), .dw(dw)) u_cmp (
      .rd_addr (bus.rd_addr[i*aw +: aw]),
      .we      (we_q),
      .addrw   (addr_q),
      .dataw   (data_q),
      .we2     (we2_q),
      .addrw2  (addr2_q),
      .dataw2  (data2_q),
      .hit_c   (hit_c[i]),
      .data_c  (fwd_data_c[i*dw +: dw])
    );
  end

  assign bus.we         = we_q;
  assign bus.we2        = we2_q;
  assign bus.addrw      = addr_q;
  assign bus.addrw2     = addr2_q;
  assign bus.dataw      = data_q;
  assign bus.dataw2     = data2_q;
  assign bus.commit_cnt = cnt_q;
  assign bus.fwd_hit    = hit_c;
  assign bus.fwd_data   = fwd_data_c;

endmodule

// File: tb/tb_or1200_rf_wb.sv
// Bench for or1200_rf_wb: vector table through a scoreboard, then freeze/flush/reset/wrap sequences.
module tb_or1200_rf_wb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  or1200_rf_wb_if #(.aw(AW), .dw(DW), .cw(CW)) bus ();
  or1200_rf_wb #(.aw(AW), .dw(DW), .cw(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        v2;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic [19:0] rd;
    logic        xwe;
    logic        xwe2;
    logic [3:0]  xhit;
  } vec_t;

  typedef struct {
    logic         we;
    logic         we2;
    logic [4:0]   aw1;
    logic [4:0]   aw2;
    logic [31:0]  dw1;
    logic [31:0]  dw2;
    logic [3:0]   hit;
    logic [127:0] fd;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  int          vis_sum = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [4:0] a2, input logic [31:0] d2);
    bus.ex_valid  = v1;
    bus.ex_addr   = a1;
    bus.ex_data   = d1;
    bus.ex_valid2 = v2;
    bus.ex_addr2  = a2;
    bus.ex_data2  = d2;
  endtask

  // Counter model: commits what is visible unless frozen/flushed, then the stage updates.
  task automatic edge_tick(input int new_sum);
    if (!bus.wb_freeze && !bus.flushpipe) exp_cnt = exp_cnt + 16'(vis_sum);
    if (bus.flushpipe) vis_sum = 0;
    else if (!bus.wb_freeze) vis_sum = new_sum;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ports(input string nm, input exp_t e);
    chk({nm, ".we"},     bus.we,       e.we);
    chk({nm, ".we2"},    bus.we2,      e.we2);
    chk({nm, ".addrw"},  bus.addrw,    e.aw1);
    chk({nm, ".addrw2"}, bus.addrw2,   e.aw2);
    chk({nm, ".dataw"},  bus.dataw,    e.dw1);
    chk({nm, ".dataw2"}, bus.dataw2,   e.dw2);
    chk({nm, ".hit"},    bus.fwd_hit,  e.hit);
    chk({nm, ".fdata"},  bus.fwd_data, e.fd);
  endtask

  exp_t e;
  exp_t h;

  initial begin
    vecs[0] = '{1'b1, 5'd1,  32'h12345678, 1'b1, 5'd2,  32'h90ABCDEF, {5'd0, 5'd3, 5'd2, 5'd1},   1'b1, 1'b1, 4'b0011};
    vecs[1] = '{1'b1, 5'd13, 32'h23456789, 1'b1, 5'd13, 32'h0ABCDEF1, {5'd0, 5'd0, 5'd0, 5'd13},  1'b0, 1'b1, 4'b0001};
    vecs[2] = '{1'b1, 5'd0,  32'hAAAA0000, 1'b1, 5'd14, 32'h14141414, {5'd0, 5'd0, 5'd14, 5'd0},  1'b0, 1'b1, 4'b0010};
    vecs[3] = '{1'b1, 5'd5,  32'h00000055, 1'b0, 5'd5,  32'h00000099, {5'd0, 5'd0, 5'd0, 5'd5},   1'b1, 1'b0, 4'b0001};
    vecs[4] = '{1'b0, 5'd7,  32'h00000077, 1'b0, 5'd8,  32'h00000088, {5'd0, 5'd0, 5'd8, 5'd7},   1'b0, 1'b0, 4'b0000};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 32'hDEADBEEF, {5'd0, 5'd31, 5'd30, 5'd31}, 1'b1, 1'b1, 4'b0111};
    vecs[6] = '{1'b0, 5'd3,  32'h00000033, 1'b1, 5'd3,  32'h00000066, {5'd0, 5'd0, 5'd3, 5'd3},   1'b0, 1'b1, 4'b0011};
    vecs[7] = '{1'b1, 5'd4,  32'h00000044, 1'b1, 5'd0,  32'h00000000, {5'd4, 5'd0, 5'd0, 5'd4},   1'b1, 1'b0, 4'b1001};

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.wb_freeze = 1'b0;
    bus.flushpipe = 1'b0;
    bus.rd_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
    #2;
    h = '{1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 4'b0000, 128'd0};
    chk_ports("reset", h);
    chk("reset.cnt", bus.commit_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].v2, vecs[i].a2, vecs[i].d2);
      e.we  = vecs[i].xwe;
      e.we2 = vecs[i].xwe2;
      e.aw1 = vecs[i].a1;
      e.aw2 = vecs[i].a2;
      e.dw1 = vecs[i].d1;
      e.dw2 = vecs[i].d2;
      e.hit = vecs[i].xhit;
      e.fd  = '0;
      for (int p = 0; p < 4; p++) begin
        logic [4:0] r;
        r = vecs[i].rd[p*5 +: 5];
        if (vecs[i].xhit[p])
          e.fd[p*32 +: 32] = (vecs[i].xwe2 && vecs[i].a2 == r) ? vecs[i].d2 : vecs[i].d1;
      end
      sbq.push_back(e);
      edge_tick(int'(vecs[i].xwe) + int'(vecs[i].xwe2));
      bus.rd_addr = vecs[i].rd;
      #1;
      e = sbq.pop_front();
      chk_ports($sformatf("vec%0d", i), e);
      chk($sformatf("vec%0d.cnt", i), bus.commit_cnt, exp_cnt);
    end

    // r0 write plus three frozen cycles with fresh inputs.
    drive(1'b1, 5'd0, 32'hAAAA0000, 1'b1, 5'd14, 32'h14141414);
    edge_tick(1);
    bus.rd_addr = {5'd0, 5'd0, 5'd14, 5'd0};
    #1;
    h = '{1'b0, 1'b1, 5'd0, 5'd14, 32'hAAAA0000, 32'h14141414, 4'b0010, {64'd0, 32'h14141414, 32'd0}};
    chk_ports("r0", h);
    bus.wb_freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd6, $urandom, 1'b1, 5'd7, $urandom);
      edge_tick(2);
      chk_ports($sformatf("frz%0d", k), h);
      chk($sformatf("frz%0d.cnt", k), bus.commit_cnt, exp_cnt);
    end
    bus.wb_freeze = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    edge_tick(0);
    chk("unfrz.cnt", bus.commit_cnt, exp_cnt);
    chk("unfrz.we2", bus.we2, 1'b0);

    // Flush during freeze with stage TWO.
    drive(1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222);
    edge_tick(2);
    bus.rd_addr = {5'd0, 5'd0, 5'd2, 5'd1};
    #1;
    chk("two.we", bus.we, 1'b1);
    chk("two.we2", bus.we2, 1'b1);
    chk("two.hit", bus.fwd_hit, 4'b0011);
    bus.wb_freeze = 1'b1;
    bus.flushpipe = 1'b1;
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd10, 32'hAAAAAAAA);
    edge_tick(2);
    h = '{1'b0, 1'b0, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 4'b0000, 128'd0};
    chk_ports("flush", h);
    chk("flush.cnt", bus.commit_cnt, exp_cnt);
    bus.wb_freeze = 1'b0;
    bus.flushpipe = 1'b0;

    // Asynchronous reset while stage TWO is held.
    drive(1'b1, 5'd9, 32'h09090909, 1'b1, 5'd10, 32'h10101010);
    edge_tick(2);
    bus.wb_freeze = 1'b1;
    edge_tick(0);
    bus.rd_addr = {5'd0, 5'd0, 5'd10, 5'd9};
    #3;
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    vis_sum = 0;
    h = '{1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 4'b0000, 128'd0};
    chk_ports("rstmid", h);
    chk("rstmid.cnt", bus.commit_cnt, 16'd0);
    bus.wb_freeze = 1'b0;
    drive(1'b0, 5'd9, 32'h0000CAFE, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_tick(0);
    chk("rel.we", bus.we, 1'b0);
    drive(1'b1, 5'd9, 32'h0000CAFE, 1'b0, 5'd0, 32'd0);
    edge_tick(1);
    chk("rel.we1", bus.we, 1'b1);
    chk("rel.addrw", bus.addrw, 5'd9);
    chk("rel.dataw", bus.dataw, 32'h0000CAFE);
    chk("rel.cnt", bus.commit_cnt, 16'd0);

    // Counter wrap across an increment of two.
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = 16'd0;
    vis_sum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
    edge_tick(1);
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    repeat (32768) edge_tick(2);
    chk("wrap.pre", bus.commit_cnt, 16'hFFFF);
    chk("wrap.model", exp_cnt, 16'hFFFF);
    edge_tick(2);
    chk("wrap.post", bus.commit_cnt, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
